// File: rtl/ro_freq_meter_if.sv
// Measurement request/result bundle between the ring-oscillator meter and the chip readout logic.
// start is a one-cycle request; valid is held until ack or a new start, and ack has effect only while valid=1.
interface ro_freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             ack;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (output start, ack, input busy, valid, count, overflow);
  modport slave  (input start, ack, output busy, valid, count, overflow);
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: synchronises osc_in and counts its rising edges
// over a GATE_CYCLES window of clk, then presents the count until acknowledged.
module ro_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  osc_in,
  ro_freq_meter_if.slave        bus,
  output logic [1:0]            dbg_state_o
);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, GATE, DONE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GW-1:0]          gate_cnt_q;
  logic [FW-1:0]          flush_cnt_q;
  logic [CNT_W-1:0]       count_q;
  logic                   overflow_q;
  logic                   busy_q;
  logic                   valid_q;
  logic                   osc_edge;
  logic                   start_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);

  // FLUSH length equals the synchroniser depth, so edges already in flight at start are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gate_cnt_q  <= '0;
      flush_cnt_q <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else if (start_ok) begin
      state_q     <= FLUSH;
      flush_cnt_q <= FW'(SYNC_STAGES);
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        FLUSH: begin
          if (flush_cnt_q == FW'(1)) begin
            state_q    <= GATE;
            gate_cnt_q <= GW'(GATE_CYCLES);
          end else begin
            flush_cnt_q <= flush_cnt_q - FW'(1);
          end
        end
        GATE: begin
          if (osc_edge) begin
            if (count_q == {CNT_W{1'b1}}) overflow_q <= 1'b1;
            else                          count_q    <= count_q + CNT_W'(1);
          end
          if (gate_cnt_q == GW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            gate_cnt_q <= gate_cnt_q - GW'(1);
          end
        end
        DONE: begin
          if (bus.ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed and randomised measurements of ro_freq_meter against a sampled-waveform edge-count model.
module tb_ro_freq_meter;
  localparam int G     = 40;
  localparam int CW    = 4;
  localparam int S     = 2;
  localparam int MAXC  = (1 << CW) - 1;
  localparam int HSIZE = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       osc_in = 1'b0;
  logic [1:0] dbg_state;

  ro_freq_meter_if #(.CNT_W(CW)) bus_if ();

  ro_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .osc_in      (osc_in),
    .bus         (bus_if.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int osc_mode = 3;
  int half = 2;
  int ph_cnt = 0;
  int last_t = 0;
  int last_ec = 0;
  bit smp [HSIZE];
  logic [CW-1:0] exp_q[$];

  // osc_in value seen at every posedge, indexed by posedge number
  always @(posedge clk) begin
    if (cyc < HSIZE) smp[cyc] = osc_in;
    cyc++;
  end

  // modes: 0 low, 1 high, 2 square with half-period 'half', 3 random hold 1..4, other manual
  always @(negedge clk) begin
    case (osc_mode)
      0: osc_in = 1'b0;
      1: osc_in = 1'b1;
      2: begin
        if (ph_cnt >= half - 1) begin osc_in = ~osc_in; ph_cnt = 0; end
        else ph_cnt++;
      end
      3: begin
        if (ph_cnt <= 0) begin osc_in = ~osc_in; ph_cnt = $urandom_range(0, 3); end
        else ph_cnt--;
      end
      default: ;
    endcase
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no end of run, expected finish before 300000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising transitions of the sampled waveform between consecutive samples t..t+G, saturating at MAXC.
  task automatic model(input int t, output int ec, output bit eo);
    ec = 0;
    eo = 1'b0;
    for (int j = t + 1; j <= t + G; j++) begin
      if (smp[j] && !smp[j-1]) begin
        if (ec == MAXC) eo = 1'b1;
        else ec++;
      end
    end
  endtask

  task automatic do_start(input bit with_ack, input bit raise_osc);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.ack   = with_ack;
    if (raise_osc) osc_in = 1'b1;
    last_t = cyc;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.ack   = 1'b0;
  endtask

  task automatic run_meas(input string tag, input bit disturb, input bit with_ack, input bit raise_osc);
    int n;
    int ec;
    bit eo;
    do_start(with_ack, raise_osc);
    check({tag, "_busy_lat"}, bus_if.busy, 1);
    check({tag, "_valid_low"}, bus_if.valid, 0);
    if (with_ack) check({tag, "_cleared"}, bus_if.count, 0);
    n = 0;
    while (bus_if.valid !== 1'b1 && n < S + G + 20) begin
      bus_if.start = disturb && (n == 4 || n == 9);
      @(negedge clk);
      n++;
    end
    bus_if.start = 1'b0;
    check({tag, "_valid_lat"}, cyc, last_t + S + G + 1);
    model(last_t, ec, eo);
    exp_q.push_back(CW'(ec));
    last_ec = ec;
    check({tag, "_count"}, bus_if.count, exp_q.pop_front());
    check({tag, "_ovf"}, bus_if.overflow, eo);
    check({tag, "_busy_done"}, bus_if.busy, 0);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    bus_if.ack = 1'b1;
    @(negedge clk);
    bus_if.ack = 1'b0;
    check({tag, "_ack_valid"}, bus_if.valid, 0);
    check({tag, "_ack_count"}, bus_if.count, last_ec);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.ack   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus_if.busy, 0);
    check("rst_valid", bus_if.valid, 0);
    check("rst_count", bus_if.count, 0);
    check("rst_ovf", bus_if.overflow, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", bus_if.busy, 0);
    check("idle_valid", bus_if.valid, 0);

    // known frequency: period 4 clk over 40 samples gives 10 rising edges
    osc_mode = 2; half = 2;
    run_meas("known", 0, 0, 0);
    check("known_const", bus_if.count, 10);
    do_ack("known");

    osc_mode = 0;
    repeat (3) @(negedge clk);
    run_meas("dc0", 0, 0, 0);
    check("dc0_const", bus_if.count, 0);
    osc_mode = 1;
    repeat (3) @(negedge clk);
    run_meas("dc1", 0, 0, 0);
    check("dc1_const", bus_if.count, 0);

    // single rise that reaches the edge detector only while flushing
    osc_mode = 4;
    osc_in = 1'b0;
    repeat (4) @(negedge clk);
    run_meas("flush_rise", 0, 0, 1);
    check("flush_rise_const", bus_if.count, 0);

    // period 2 clk gives 20 edges, saturating a 4-bit count
    osc_mode = 2; half = 1;
    run_meas("sat", 0, 0, 0);
    check("sat_const", bus_if.count, MAXC);
    check("sat_ovf_const", bus_if.overflow, 1);
    osc_mode = 0;
    run_meas("after_sat", 0, 0, 0);
    check("after_sat_ovf", bus_if.overflow, 0);
    do_ack("after_sat");

    // start together with ack while DONE restarts the measurement
    osc_mode = 2; half = 3;
    run_meas("pre_sa", 0, 0, 0);
    run_meas("start_ack", 0, 1, 0);

    // start pulses during GATE must not disturb the result or its timing
    osc_mode = 3;
    run_meas("disturb", 1, 0, 0);
    do_ack("disturb");

    // reset five cycles into GATE
    osc_mode = 2; half = 1;
    do_start(0, 0);
    repeat (S + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_valid", bus_if.valid, 0);
    check("midrst_count", bus_if.count, 0);
    check("midrst_ovf", bus_if.overflow, 0);
    repeat (S + G + 5) @(negedge clk);
    check("midrst_stays_idle", bus_if.valid, 0);
    osc_mode = 2; half = 2;
    run_meas("post_rst", 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      osc_mode = $urandom_range(2, 3);
      half = $urandom_range(1, 4);
      run_meas("rand", $urandom_range(0, 1), 0, 0);
      if ($urandom_range(0, 1) == 1) do_ack("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Measurement end of the on-chip ring oscillator: samples the free-running oscillator tap (asynchronous to clk) and counts its rising edges over a fixed gate window of clk cycles.
- Reports the edge count to the chip-level readout logic through a valid/ack handshake.
- Sits between the oscillator output and the uo_out/uio readout path.
- The oscillator is characterised from count / GATE_CYCLES × f_clk.

Parameters:
- GATE_CYCLES, 1000, gate window length in clk cycles; must be >= 1.
- CNT_W, 16, width of the edge-count result.
- SYNC_STAGES, 2, flip-flop stages in the osc_in synchroniser; must be >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- osc_in  input  1  ring-oscillator tap, asynchronous to clk
- start  input  1  single-cycle request to begin a measurement
- ack  input  1  consumer accepts the current result
- busy  output  1  high while a measurement is in progress (FLUSH or GATE)
- valid  output  1  result available; held until ack or a new start
- count  output  CNT_W  number of osc_in rising edges counted in the gate window
- overflow  output  1  edge count saturated during the window

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset has priority over all other inputs.
- Reset state: FSM in IDLE, busy=0, valid=0, count=0, overflow=0, synchroniser flops=0, gate counter=0.
- Synchroniser: osc_in passes through SYNC_STAGES flops. A previous-sample flop follows them.
- Edge detect: edge = sync_out & ~prev. The synchroniser and edge detector run continuously in every state.
- Aliasing: counts are exact only for osc_in high and low times of at least one clk period each. Faster inputs alias; no error is flagged.
- IDLE:
  - busy=0.
  - start=1 -> FLUSH next cycle: count cleared to 0, overflow cleared, valid=0.
- FLUSH:
  - Lasts exactly SYNC_STAGES cycles, to discard stale synchroniser history. busy=1.
  - No edges are counted.
  - Then -> GATE.
- GATE:
  - Lasts exactly GATE_CYCLES cycles. busy=1.
  - Each cycle with edge=1 increments count by 1.
  - If count == 2^CNT_W-1 and edge=1, count holds (saturates) and overflow sets; overflow stays set until the next start.
  - After the last gate cycle -> DONE.
- DONE:
  - busy=0, valid=1, count and overflow stable.
  - ack=1 -> IDLE next cycle with valid=0. count and overflow keep their values.
  - start=1 -> FLUSH, a new measurement with count cleared. start wins over a simultaneous ack.
- Latency: start sampled at cycle t -> busy=1 from t+1. valid=1 from t+1+SYNC_STAGES+GATE_CYCLES.
- start while busy (FLUSH or GATE) is ignored; the measurement continues unaffected.
- ack outside DONE is ignored.
- Reset mid-measurement: next cycle IDLE, all outputs at reset values, partial count discarded.
- Gate counter: width $clog2(GATE_CYCLES+1). It reloads at entry to GATE, so there is no wrap-around across measurements.
- All outputs are registered.

Test Plan:
- Reset/idle: rst for 2 cycles with osc_in toggling -> busy=0, valid=0, count=0, overflow=0; no change without start.
- Known frequency: GATE_CYCLES=16, osc_in toggled synchronously every 2 clk (period 4), start pulse at t -> busy at t+1; valid at t+1+SYNC_STAGES+16; count=4, overflow=0.
- DC input: osc_in held 0, then held 1, across a full measurement -> count=0 both times. Separately, a single 0->1 transition placed during FLUSH -> count=0.
- Saturation: CNT_W=4, GATE_CYCLES=64, osc_in period 2 clk (32 edges) -> count=15, overflow=1. The next start with a DC input -> count=0, overflow=0.
- Handshake:
  - ack with valid=1 -> valid=0 next cycle, count retained.
  - start and ack together in DONE -> valid=0, busy=1 next cycle, count=0.
  - start pulses during GATE -> result and latency identical to an undisturbed run.
- Reset mid-GATE: rst asserted 5 cycles into GATE -> next cycle IDLE, count=0, busy=0. A subsequent normal start gives the correct count.
